// File: rtl/bp_tanh_update.sv
// Backward pass for a tanh neuron: delta = err*(1-a^2), error to the previous layer,
// and an SGD update of weights and bias, sequenced by a small FSM around a shared multiplier.
module bp_tanh_update #(
  parameter int NUM   = 3,
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_err,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [NUM*WIDTH-1:0] i_k,
  input  logic [NUM*WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_lr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_wr,
  output logic [NUM*WIDTH-1:0] o_w,
  output logic [WIDTH-1:0]     o_b,
  output logic [WIDTH-1:0]     o_delta,
  output logic [NUM*WIDTH-1:0] o_err_prev
);

  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_DLT, S_WUP, S_BUP, S_DONE} state_e;

  // Fixed-point multiply: full-width product, arithmetic shift (truncating), then clip.
  function automatic logic [WIDTH-1:0] mul_fx(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
    p = p >>> FRAC;
    if (!p[2*WIDTH-1] && (|p[2*WIDTH-2:WIDTH-1])) return SMAX;
    if (p[2*WIDTH-1] && !(&p[2*WIDTH-2:WIDTH-1])) return SMIN;
    return p[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_sat(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    if (d[WIDTH] != d[WIDTH-1]) return d[WIDTH] ? SMIN : SMAX;
    return d[WIDTH-1:0];
  endfunction

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [WIDTH-1:0]     err_q, a_q, b_q, lr_q, sq_q, delta_q;
  logic [NUM*WIDTH-1:0] k_q, w_q, wn_q, ep_q;

  logic [WIDTH-1:0] k_cur, w_cur, mul_x, mul_y, mul_p, lrg, ep_cur;

  assign k_cur = k_q[int'(idx_q)*WIDTH +: WIDTH];
  assign w_cur = w_q[int'(idx_q)*WIDTH +: WIDTH];

  // NOTE: every variable written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      S_SQ:  begin mul_x = a_q;     mul_y = a_q;                 end
      S_DLT: begin mul_x = err_q;   mul_y = sub_sat(ONE, sq_q);  end
      S_WUP: begin mul_x = delta_q; mul_y = k_cur;               end
      S_BUP: begin mul_x = lr_q;    mul_y = delta_q;             end
      default: ;
    endcase
  end

  assign mul_p  = mul_fx(mul_x, mul_y);
  assign lrg    = mul_fx(lr_q, mul_p);
  assign ep_cur = mul_fx(delta_q, w_cur);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_SQ;
      S_SQ:   state_d = S_DLT;
      S_DLT:  state_d = S_WUP;
      S_WUP:  if (idx_q == IW'(NUM - 1)) state_d = S_BUP;
      S_BUP:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);
  assign o_wr   = o_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers are reset too, because an aborted job must leave all outputs at zero.
      state_q    <= S_IDLE;
      idx_q      <= '0;
      err_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      lr_q       <= '0;
      k_q        <= '0;
      w_q        <= '0;
      sq_q       <= '0;
      delta_q    <= '0;
      wn_q       <= '0;
      ep_q       <= '0;
      o_w        <= '0;
      o_b        <= '0;
      o_delta    <= '0;
      o_err_prev <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (i_start) begin
          err_q <= i_err;
          a_q   <= i_a;
          k_q   <= i_k;
          w_q   <= i_w;
          b_q   <= i_b;
          lr_q  <= i_lr;
          idx_q <= '0;
        end
        S_SQ:  sq_q    <= mul_p;
        S_DLT: delta_q <= mul_p;
        S_WUP: begin
          wn_q[int'(idx_q)*WIDTH +: WIDTH] <= sub_sat(w_cur, lrg);
          ep_q[int'(idx_q)*WIDTH +: WIDTH] <= ep_cur;
          idx_q <= (idx_q == IW'(NUM - 1)) ? '0 : idx_q + IW'(1);
        end
        // Results become visible together as DONE is entered.
        S_BUP: begin
          o_w        <= wn_q;
          o_err_prev <= ep_q;
          o_delta    <= delta_q;
          o_b        <= sub_sat(b_q, mul_p);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_tanh_update.sv
// Scoreboard bench for bp_tanh_update: a longint reference model predicts each job,
// and a negedge monitor pops and compares whenever o_done fires.
module tb_bp_tanh_update;

  localparam int NUM   = 3;
  localparam int W     = 32;
  localparam int FRAC  = 24;
  localparam int LAT   = NUM + 3;
  localparam int JOB_T = NUM + 5;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -LMAX - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_start = 1'b0;
  logic [W-1:0]     i_err = '0, i_a = '0, i_b = '0, i_lr = '0;
  logic [NUM*W-1:0] i_k = '0, i_w = '0;
  logic             o_busy, o_done, o_wr;
  logic [NUM*W-1:0] o_w, o_err_prev;
  logic [W-1:0]     o_b, o_delta;

  int checks = 0, failures = 0;
  int edge_cnt = 0, wr_count = 0, last_done_edge = 0, start_edge = 0;

  typedef struct {
    logic [NUM*W-1:0] w;
    logic [NUM*W-1:0] ep;
    logic [W-1:0]     b;
    logic [W-1:0]     d;
  } exp_t;
  exp_t sb_q[$];

  bp_tanh_update #(.NUM(NUM), .WIDTH(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_err(i_err), .i_a(i_a), .i_k(i_k), .i_w(i_w), .i_b(i_b), .i_lr(i_lr),
    .o_busy(o_busy), .o_done(o_done), .o_wr(o_wr),
    .o_w(o_w), .o_b(o_b), .o_delta(o_delta), .o_err_prev(o_err_prev)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  function automatic logic [31:0] m_clip(input longint v);
    if (v > LMAX) return 32'h7FFFFFFF;
    if (v < LMIN) return 32'h80000000;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'(signed'(x)) * longint'(signed'(y));
    return m_clip(p >>> FRAC);
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] x, input logic [31:0] y);
    return m_clip(longint'(signed'(x)) - longint'(signed'(y)));
  endfunction

  task automatic push_expected();
    exp_t e;
    logic [31:0] sq, d, g;
    sq = m_mul(i_a, i_a);
    d  = m_mul(i_err, m_sub(32'h01000000, sq));
    for (int i = 0; i < NUM; i++) begin
      g = m_mul(d, i_k[i*W +: W]);
      e.w[i*W +: W]  = m_sub(i_w[i*W +: W], m_mul(i_lr, g));
      e.ep[i*W +: W] = m_mul(d, i_w[i*W +: W]);
    end
    e.b = m_sub(i_b, m_mul(i_lr, d));
    e.d = d;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (o_done || o_wr) begin
      checks++;
      if (o_wr !== o_done) begin
        failures++;
        $display("FAIL wr_strobe: o_wr=%b o_done=%b", o_wr, o_done);
      end
    end
    if (o_done === 1'b1) begin
      wr_count++;
      last_done_edge = edge_cnt;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done: o_done with no job expected");
      end else begin
        e = sb_q.pop_front();
        checks += 4;
        if (o_delta !== e.d) begin
          failures++; $display("FAIL sb_delta: got %h want %h", o_delta, e.d);
        end
        if (o_w !== e.w) begin
          failures++; $display("FAIL sb_w: got %h want %h", o_w, e.w);
        end
        if (o_b !== e.b) begin
          failures++; $display("FAIL sb_b: got %h want %h", o_b, e.b);
        end
        if (o_err_prev !== e.ep) begin
          failures++; $display("FAIL sb_err_prev: got %h want %h", o_err_prev, e.ep);
        end
      end
    end
  end

  task automatic set_t1();
    i_err = 32'h01000000;
    i_a   = 32'h00800000;
    i_lr  = 32'h00800000;
    i_k   = {32'hFF000000, 32'h00800000, 32'h01000000};
    i_w   = {32'hFF800000, 32'h00000000, 32'h00400000};
    i_b   = 32'h00200000;
  endtask

  task automatic start_job();
    @(negedge clk);
    i_start = 1'b1;
    push_expected();
    start_edge = edge_cnt + 1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  prev;
    bit  seen;
    prev = wr_count;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk); #1;
      if (wr_count > prev) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no o_done want o_done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_wr} !== 3'b000 || o_w !== '0 || o_b !== '0 ||
        o_delta !== '0 || o_err_prev !== '0) begin
      failures++;
      $display("FAIL reset_state: busy/done/wr=%b%b%b w=%h b=%h d=%h ep=%h want all 0",
               o_busy, o_done, o_wr, o_w, o_b, o_delta, o_err_prev);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    set_t1();
    start_job();
    @(negedge clk); i_start = 1'b0; #1;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL nominal_busy: got %b want 1", o_busy);
    end
    wait_done("nominal", 40);
    checks += 5;
    if (last_done_edge - start_edge !== LAT) begin
      failures++; $display("FAIL nominal_latency: got %0d want %0d", last_done_edge - start_edge, LAT);
    end
    if (o_delta !== 32'h00C00000) begin
      failures++; $display("FAIL nominal_delta: got %h want 00c00000", o_delta);
    end
    if (o_w !== {32'hFFE00000, 32'hFFD00000, 32'hFFE00000}) begin
      failures++; $display("FAIL nominal_w: got %h want ffe00000ffd00000ffe00000", o_w);
    end
    if (o_b !== 32'hFFC00000) begin
      failures++; $display("FAIL nominal_b: got %h want ffc00000", o_b);
    end
    if (o_err_prev !== {32'hFFA00000, 32'h00000000, 32'h00300000}) begin
      failures++; $display("FAIL nominal_err_prev: got %h want ffa000000000000000300000", o_err_prev);
    end
    @(negedge clk); #1;
    checks += 2;
    if ({o_done, o_wr, o_busy} !== 3'b000) begin
      failures++; $display("FAIL nominal_pulse_width: done/wr/busy=%b%b%b want 000", o_done, o_wr, o_busy);
    end
    if (o_w !== {32'hFFE00000, 32'hFFD00000, 32'hFFE00000}) begin
      failures++; $display("FAIL nominal_hold: got %h want ffe00000ffd00000ffe00000", o_w);
    end
  endtask

  task automatic test_delta_zero();
    set_t1();
    i_a = 32'h01000000;
    start_job();
    @(negedge clk); i_start = 1'b0;
    wait_done("delta_zero", 40);
    checks += 4;
    if (o_delta !== '0) begin
      failures++; $display("FAIL dz_delta: got %h want 0", o_delta);
    end
    if (o_w !== i_w) begin
      failures++; $display("FAIL dz_w: got %h want %h", o_w, i_w);
    end
    if (o_b !== i_b) begin
      failures++; $display("FAIL dz_b: got %h want %h", o_b, i_b);
    end
    if (o_err_prev !== '0) begin
      failures++; $display("FAIL dz_err_prev: got %h want 0", o_err_prev);
    end
  endtask

  task automatic test_saturation();
    set_t1();
    i_err = 32'h7FFFFFFF;
    i_lr  = 32'h7FFFFFFF;
    i_a   = 32'h00000000;
    i_k[31:0] = 32'h7FFFFFFF;
    i_w[31:0] = 32'hFF000000;
    start_job();
    @(negedge clk); i_start = 1'b0;
    wait_done("saturation", 40);
    checks += 2;
    if (o_w[31:0] !== 32'h80000000) begin
      failures++; $display("FAIL sat_w0: got %h want 80000000", o_w[31:0]);
    end
    if (o_delta !== 32'h7FFFFFFF) begin
      failures++; $display("FAIL sat_delta: got %h want 7fffffff", o_delta);
    end
  endtask

  task automatic test_ignore_start();
    int prev;
    prev = wr_count;
    set_t1();
    start_job();
    @(negedge clk); i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_start = 1'b1;
    i_err = $urandom; i_a = $urandom; i_b = $urandom; i_lr = $urandom;
    i_k = {$urandom, $urandom, $urandom};
    i_w = {$urandom, $urandom, $urandom};
    @(negedge clk); i_start = 1'b0;
    wait_done("ignore_start", 40);
    checks++;
    if (o_delta !== 32'h00C00000) begin
      failures++; $display("FAIL ignore_delta: got %h want 00c00000", o_delta);
    end
    repeat (2 * JOB_T) @(negedge clk);
    #1;
    checks++;
    if (wr_count - prev !== 1) begin
      failures++; $display("FAIL ignore_wr_count: got %0d want 1", wr_count - prev);
    end
  endtask

  task automatic test_reset_mid();
    int   prev;
    exp_t dropped;
    set_t1();
    start_job();
    @(negedge clk); i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    dropped = sb_q.pop_back();
    prev = wr_count;
    checks++;
    if ({o_busy, o_done, o_wr} !== 3'b000 || o_w !== '0 || o_b !== '0 ||
        o_delta !== '0 || o_err_prev !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: busy/done/wr=%b%b%b w=%h b=%h d=%h ep=%h want all 0",
               o_busy, o_done, o_wr, o_w, o_b, o_delta, o_err_prev);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2 * JOB_T) @(negedge clk);
    #1;
    checks++;
    if (wr_count !== prev || o_busy !== 1'b0) begin
      failures++; $display("FAIL midreset_no_wr: wr pulses %0d busy %b want 0 and 0", wr_count - prev, o_busy);
    end
    set_t1();
    start_job();
    @(negedge clk); i_start = 1'b0;
    wait_done("after_reset", 40);
    checks++;
    if (o_b !== 32'hFFC00000) begin
      failures++; $display("FAIL after_reset_b: got %h want ffc00000", o_b);
    end
  endtask

  task automatic test_back_to_back();
    int prev, d1, d2, d3;
    prev = wr_count;
    i_err = 32'hFF800000;
    i_a   = 32'hFF400000;
    i_lr  = 32'h00200000;
    i_b   = $urandom;
    i_k   = {$urandom, $urandom, $urandom};
    i_w   = {$urandom, $urandom, $urandom};
    start_job();
    push_expected();
    push_expected();
    wait_done("b2b_1", 40); d1 = last_done_edge;
    wait_done("b2b_2", 40); d2 = last_done_edge;
    wait_done("b2b_3", 40); d3 = last_done_edge;
    i_start = 1'b0;
    checks += 3;
    if (d1 - start_edge !== LAT) begin
      failures++; $display("FAIL b2b_latency: got %0d want %0d", d1 - start_edge, LAT);
    end
    if (d2 - d1 !== JOB_T || d3 - d2 !== JOB_T) begin
      failures++; $display("FAIL b2b_period: got %0d,%0d want %0d", d2 - d1, d3 - d2, JOB_T);
    end
    repeat (2 * JOB_T) @(negedge clk);
    #1;
    if (wr_count - prev !== 3) begin
      failures++; $display("FAIL b2b_wr_count: got %0d want 3", wr_count - prev);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_delta_zero();
    test_saturation();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover: got %0d pending jobs want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
